// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the handshaked pipeline register: occupancy encoding and the
// MIPS stage-word widths used by the pipelined datapath instances.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } occ_e;

  localparam int unsigned IF_ID_WIDTH  = 64;
  localparam int unsigned ID_EX_WIDTH  = 147;
  localparam int unsigned EX_MEM_WIDTH = 107;
  localparam int unsigned MEM_WB_WIDTH = 71;

endpackage

// File: rtl/pipe_skid_reg_dff_en_sync.sv
// Enabled register with synchronous active-high reset to a programmable value.
module dff_en_sync #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= INIT_VALUE;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a two-entry skid buffer, flush and reset value.
// in_ready depends only on the state flop, so there is no combinational path from out_ready.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_occupancy
);

  occ_e             r_state;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign o_in_ready  = (r_state != StFull);
  assign o_out_valid = (r_state != StEmpty);
  assign o_occupancy = r_state;
  assign o_out_data  = w_main_q;

  assign w_in_fire  = i_in_valid & o_in_ready;
  assign w_out_fire = o_out_valid & i_out_ready;

  // Flush leaves both data registers untouched; only the state is cleared.
  always_comb begin
    w_main_en = 1'b0;
    w_skid_en = 1'b0;
    w_main_d  = i_in_data;
    if (!i_flush) begin
      unique case (r_state)
        StEmpty: w_main_en = w_in_fire;
        StOne: begin
          w_main_en = w_in_fire & w_out_fire;
          w_skid_en = w_in_fire & ~w_out_fire;
        end
        StFull: begin
          w_main_en = w_out_fire;
          w_main_d  = w_skid_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state <= StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: if (w_in_fire) r_state <= StOne;
        StOne: begin
          if (w_in_fire && !w_out_fire) begin
            r_state <= StFull;
          end else if (!w_in_fire && w_out_fire) begin
            r_state <= StEmpty;
          end
        end
        StFull:  if (w_out_fire) r_state <= StOne;
        default: r_state <= StEmpty;
      endcase
    end
  end

  dff_en_sync #(
    .WIDTH      (WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_main (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  dff_en_sync #(
    .WIDTH      (WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) u_skid (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_skid_en),
    .i_d   (i_in_data),
    .o_q   (w_skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int unsigned WIDTH      = 32;
  localparam logic [31:0] INIT_VALUE = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .WIDTH      (WIDTH),
    .INIT_VALUE (INIT_VALUE)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_occupancy (occupancy)
  );

  // Apply one cycle of stimulus and advance the reference queue to match.
  task automatic drive(input logic v, input logic [31:0] d, input logic r,
                       input logic fl, input logic rs);
    logic ifire, ofire;
    rst = rs; flush = fl; in_valid = v; in_data = d; out_ready = r;
    ifire = v && (q.size() < 2);
    ofire = r && (q.size() > 0);
    @(posedge clk);
    #1;
    if (rs || fl) begin
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(d);
    end
  endtask

  task automatic test_reset;
    drive(1'b1, 32'h1234, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 32'h1234, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    n_tests++;
    if (occupancy !== 2'd0) begin
      n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy);
    end
    n_tests++;
    if (out_data !== INIT_VALUE) begin
      n_fail++; $display("FAIL reset_out_data: got %h want %h", out_data, INIT_VALUE);
    end
  endtask

  task automatic test_streaming;
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || in_ready !== 1'b1
          || occupancy !== 2'd1) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%b d=%0d rdy=%b occ=%0d want v=1 d=%0d rdy=1 occ=1",
                 i, out_valid, out_data, in_ready, occupancy, i);
      end
    end
  endtask

  task automatic test_backpressure;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'd5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd6, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'd5) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d rdy=%b d=%0d want occ=2 rdy=0 d=5",
               occupancy, in_ready, out_data);
    end
    drive(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'd5 || occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_stable: got v=%b d=%0d occ=%0d want v=1 d=5 occ=2",
               out_valid, out_data, occupancy);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (out_data !== 32'd6 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_drain1: got d=%0d rdy=%b occ=%0d want d=6 rdy=1 occ=1",
               out_data, in_ready, occupancy);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_drain2: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush;
    drive(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd8, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd9, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
    end
    drive(1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd9, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_one: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_no_9: got v=%b d=%0d want v=0", out_valid, out_data);
      end
    end
  endtask

  task automatic test_reset_midop;
    drive(1'b1, 32'd11, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd12, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'd13, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1
        || out_data !== INIT_VALUE) begin
      n_fail++;
      $display("FAIL rst_midop: got occ=%0d v=%b rdy=%b d=%h want occ=0 v=0 rdy=1 d=%h",
               occupancy, out_valid, in_ready, out_data, INIT_VALUE);
    end
  endtask

  task automatic test_random;
    int errs = 0;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 511) == 0));
      n_tests++;
      if (occupancy !== 2'(q.size()) || out_valid !== (q.size() > 0)
          || in_ready !== (q.size() < 2) || (q.size() > 0 && out_data !== q[0])) begin
        n_fail++;
        errs++;
        if (errs <= 10) begin
          $display("FAIL random_cyc%0d: got occ=%0d v=%b rdy=%b d=%h want occ=%0d head=%h",
                   i, occupancy, out_valid, in_ready, out_data, q.size(),
                   (q.size() > 0) ? q[0] : 32'h0);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
